lfsr_seq_ctrl: RTL and testbench
================================

// Module: lfsr_seq_ctrl
// PURPOSE
//  Sequencer for the LFSR sequence datapath. Sits between the debounced/divided front end and
//  the LFSR: issues single-cycle step/load strobes in manual or auto-paced mode, and measures
//  the sequence period for the current characteristic polynomial. Period feeds BCD/7-seg path.
// PARAMETERS
//  WIDTH      8    LFSR state width; also width of period counter and period output
//  RATE_W     8    width of auto-pace rate input
//  MAX_STEPS  255  step limit before a measurement times out (must be <= 2^WIDTH-1)
// PORTS
//  clk           in   1       system clock; all logic on rising edge
//  rst           in   1       asynchronous, active-high reset
//  nxt           in   1       debounced single-cycle manual step request
//  tick          in   1       single-cycle pacing enable from frequency divider
//  auto_en       in   1       1 = auto-step every `rate` ticks, 0 = manual only
//  rate          in   RATE_W  ticks per auto step; 0 treated as 1
//  meas_req      in   1       single-cycle request to measure period
//  poly          in   4       current characteristic polynomial (change detection only)
//  seq_in        in   WIDTH   LFSR current state; updates the cycle after step/load is high
//  step          out  1       one-cycle strobe: advance LFSR
//  load          out  1       one-cycle strobe: reload LFSR seed
//  period        out  WIDTH   last measured period (steps to recurrence)
//  period_valid  out  1       period holds a valid result for current poly
//  timeout       out  1       last measurement hit MAX_STEPS without recurrence
//  busy          out  1       measurement in progress
// BEHAVIOUR
//  - Reset: state IDLE; step, load, period, period_valid, timeout, busy, tick count, ref all 0;
//    poly_q <= poly on first clock after reset deasserts. Reset mid-measurement aborts silently.
//  - All outputs registered. States: IDLE, LOAD, CAPT, STEP, CHK.
//  - IDLE priority (same cycle): meas_req > nxt > auto tick.
//    meas_req -> LOAD (no step issued). nxt -> step=1 next cycle, auto tick count cleared.
//    auto_en & tick: tick count +1; when count reaches max(rate,1)-1 -> step=1 next cycle,
//    count cleared. auto_en=0 holds count at 0. step never high two consecutive cycles in IDLE.
//  - LOAD: load=1 for this cycle -> CAPT.  CAPT: ref <= seq_in (seed), cnt <= 0 -> STEP.
//  - STEP: step=1, cnt <= cnt+1 -> CHK.
//  - CHK: seq_in == ref -> period <= cnt, period_valid=1, timeout=0, -> IDLE;
//    else cnt == MAX_STEPS -> period <= 0, period_valid=0, timeout=1, -> IDLE; else -> STEP.
//  - Latency: busy high LOAD..CHK = 2 + 2*P cycles for period P; results update on exit edge.
//  - busy=1 in LOAD/CAPT/STEP/CHK. nxt, tick, meas_req while busy are dropped, not queued;
//    auto tick count frozen while busy.
//  - Constant (stuck) seq_in, e.g. all-zero lockup: recurrence after 1 step -> period=1, valid.
//  - poly != poly_q (any state): poly_q <= poly, period_valid <= 0, timeout <= 0; if busy,
//    abort to IDLE next cycle with no further step/load; period keeps old value.
//  - poly change and meas_req in same IDLE cycle: invalidate, then measurement starts (LOAD).
// STRUCTURE
//  - Shared package lfsr_ctrl_pkg: state encodings (IDLE..CHK), default WIDTH/RATE_W/MAX_STEPS.
//  - One sub-module: rate_pacer (tick counter, rate 0->1 clamp, clear/freeze inputs, fire out).
//  - FSM, ref/cnt registers, compare and result registers in this module.
// TESTING
//  1 Assert rst mid-CHK -> all outputs 0 same cycle (async), IDLE after release, no step/load.
//  2 auto_en=0, nxt pulse in IDLE -> step high exactly 1 cycle, next cycle; nxt while busy -> none.
//  3 auto_en=1, rate=3, tick every 4 clk -> step after every 3rd tick; rate=0 -> step per tick.
//  4 LFSR model x^4+x^3+1, seed 5, meas_req -> load 1 cycle, period=15, period_valid=1,
//    timeout=0, busy high 32 cycles.
//  5 constant seq_in=0x00 -> period=1 valid; free-running counter model, MAX_STEPS=20 ->
//    timeout=1, period=0, period_valid=0 after 20 steps (busy 42 cycles).
//  6 poly change during STEP of a measurement -> busy=0 next cycle, no extra step,
//    period_valid=0, period unchanged; rerun meas_req -> new valid period.

Source files
------------

// File: rtl/lfsr_ctrl_pkg.sv
// Shared encodings and default sizing for the LFSR sequencer.
package lfsr_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CAPT = 3'd2,
      ST_STEP = 3'd3,
      ST_CHK  = 3'd4
   } state_e;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_RATE_W    = 8;
   localparam int DEF_MAX_STEPS = 255;

endpackage

// File: rtl/rate_pacer.sv
// Counts pacing ticks and fires once every max(rate,1) ticks; clear zeroes, freeze holds.
module rate_pacer
   import lfsr_ctrl_pkg::*;
#(
   parameter int RATE_W = DEF_RATE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tick_i,
   input  logic              auto_en_i,
   input  logic [RATE_W-1:0] rate_i,
   input  logic              clear_i,
   input  logic              freeze_i,
   output logic              fire_o
);

   logic [RATE_W-1:0] cnt_q, cnt_d;
   logic [RATE_W-1:0] lim;

   assign lim = (rate_i == '0) ? '0 : rate_i - RATE_W'(1);

   always_comb begin
      cnt_d  = cnt_q;
      fire_o = 1'b0;
      if (!auto_en_i || clear_i) begin
         cnt_d = '0;
      end else if (tick_i && !freeze_i) begin
         // >= so that lowering rate mid-count still fires instead of wrapping
         if (cnt_q >= lim) begin
            fire_o = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + RATE_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Issues step/load strobes (manual or auto-paced) and measures the LFSR period for the current poly.
// All outputs registered; a measurement keeps busy high for 2 + 2*P cycles.
module lfsr_seq_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RATE_W    = DEF_RATE_W,
   parameter int MAX_STEPS = DEF_MAX_STEPS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              nxt_i,
   input  logic              tick_i,
   input  logic              auto_en_i,
   input  logic [RATE_W-1:0] rate_i,
   input  logic              meas_req_i,
   input  logic [3:0]        poly_i,
   input  logic [WIDTH-1:0]  seq_in_i,
   output logic              step_o,
   output logic              load_o,
   output logic [WIDTH-1:0]  period_o,
   output logic              period_valid_o,
   output logic              timeout_o,
   output logic              busy_o
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_STEPS);

   state_e           state_q, state_d;
   logic             step_q, step_d;
   logic             load_q, load_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [3:0]       poly_q, poly_d;

   logic idle_free;
   logic nxt_acc;
   logic fire;

   // step_q blocks back-to-back strobes while idle
   assign idle_free = (state_q == ST_IDLE) && !step_q;
   assign nxt_acc   = idle_free && nxt_i && !meas_req_i;

   rate_pacer #(.RATE_W(RATE_W)) u_pacer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick_i),
      .auto_en_i (auto_en_i),
      .rate_i    (rate_i),
      .clear_i   (nxt_acc),
      .freeze_i  (!idle_free || meas_req_i),
      .fire_o    (fire)
   );

   always_comb begin
      state_d   = state_q;
      step_d    = 1'b0;
      cnt_d     = cnt_q;
      ref_d     = ref_q;
      period_d  = period_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      poly_d    = poly_q;

      case (state_q)
         ST_IDLE: begin
            if (meas_req_i) state_d = ST_LOAD;
            else            step_d  = nxt_acc || fire;
         end
         ST_LOAD: state_d = ST_CAPT;
         ST_CAPT: begin
            ref_d   = seq_in_i;
            cnt_d   = '0;
            state_d = ST_STEP;
         end
         ST_STEP: begin
            cnt_d   = cnt_q + WIDTH'(1);
            state_d = ST_CHK;
         end
         ST_CHK: begin
            if (seq_in_i == ref_q) begin
               period_d  = cnt_q;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (cnt_q == MAX_C) begin
               period_d  = '0;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_STEP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new polynomial invalidates results and aborts any run in flight
      if (poly_i != poly_q) begin
         poly_d    = poly_i;
         valid_d   = 1'b0;
         timeout_d = 1'b0;
         period_d  = period_q;
         if (state_q != ST_IDLE) state_d = ST_IDLE;
      end

      load_d = (state_d == ST_LOAD);
      step_d = step_d || (state_d == ST_STEP);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         step_q    <= 1'b0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         period_q  <= '0;
         ref_q     <= '0;
         cnt_q     <= '0;
         poly_q    <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         period_q  <= period_d;
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         poly_q    <= poly_d;
      end
   end

   assign step_o         = step_q;
   assign load_o         = load_q;
   assign busy_o         = busy_q;
   assign period_o       = period_q;
   assign period_valid_o = valid_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural LFSR / constant / counter datapath model.
module tb_lfsr_seq_ctrl;

   localparam int W  = 8;
   localparam int RW = 8;
   localparam int MS = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          nxt = 1'b0;
   logic          tick = 1'b0;
   logic          auto_en = 1'b0;
   logic [RW-1:0] rate = '0;
   logic          meas_req = 1'b0;
   logic [3:0]    poly = 4'h1;
   logic [W-1:0]  seq = '0;

   logic          step, load, period_valid, timeout, busy;
   logic [W-1:0]  period;

   int checks = 0;
   int failures = 0;
   int nstep = 0;
   int nload = 0;
   int mode = 0;   // 0: LFSR from poly, 1: stuck at zero, 2: free-running counter

   lfsr_seq_ctrl #(.WIDTH(W), .RATE_W(RW), .MAX_STEPS(MS)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .nxt_i          (nxt),
      .tick_i         (tick),
      .auto_en_i      (auto_en),
      .rate_i         (rate),
      .meas_req_i     (meas_req),
      .poly_i         (poly),
      .seq_in_i       (seq),
      .step_o         (step),
      .load_o         (load),
      .period_o       (period),
      .period_valid_o (period_valid),
      .timeout_o      (timeout),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s, input logic [3:0] p);
      if (p == 4'h2) return {5'b0, s[1:0], s[2] ^ s[1]};   // x^3+x^2+1
      return {4'b0, s[2:0], s[3] ^ s[2]};                 // x^4+x^3+1
   endfunction

   always @(posedge clk) begin
      if (step) nstep <= nstep + 1;
      if (load) nload <= nload + 1;
      if (mode == 1)      seq <= '0;
      else if (load)      seq <= (mode == 2) ? 8'h00 : 8'h05;
      else if (step)      seq <= (mode == 2) ? seq + 8'h01 : lfsr_next(seq, poly);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_meas(input bit poke_nxt, output int bcyc);
      meas_req = 1'b1;
      cyc();
      meas_req = 1'b0;
      bcyc = 0;
      while (busy && bcyc < 1000) begin
         nxt = poke_nxt && (bcyc == 3);
         bcyc++;
         cyc();
      end
      nxt = 1'b0;
   endtask

   task automatic wait_step(input string tag);
      int n = 0;
      while (!step && n < 100) begin
         n++;
         cyc();
      end
      if (!step) check_eq(tag, 32'(step), 32'd1);
   endtask

   initial begin
      int b, n0, l0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_step", 32'(step), 0);
      check_eq("rst_load", 32'(load), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_valid", 32'(period_valid), 0);
      check_eq("rst_timeout", 32'(timeout), 0);
      check_eq("rst_period", 32'(period), 0);
      rst = 1'b0;
      repeat (2) cyc();

      // manual step
      n0 = nstep;
      nxt = 1'b1;
      cyc();
      nxt = 1'b0;
      check_eq("nxt_step", 32'(step), 1);
      cyc();
      check_eq("nxt_one_cycle", 32'(step), 0);
      cyc();
      check_eq("nxt_count", 32'(nstep - n0), 1);

      // auto pacing, rate 3 then rate 0
      auto_en = 1'b1;
      rate = 8'd3;
      for (int i = 1; i <= 6; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         check_eq($sformatf("auto_r3_t%0d", i), 32'(step), (i % 3 == 0) ? 32'd1 : 32'd0);
         repeat (3) cyc();
      end
      rate = 8'd0;
      for (int i = 1; i <= 3; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         check_eq($sformatf("auto_r0_t%0d", i), 32'(step), 1);
         repeat (3) cyc();
      end
      auto_en = 1'b0;
      cyc();

      // stuck-at-zero datapath
      mode = 1;
      n0 = nstep;
      run_meas(1'b0, b);
      check_eq("const_busy", 32'(b), 4);
      check_eq("const_period", 32'(period), 1);
      check_eq("const_valid", 32'(period_valid), 1);
      check_eq("const_timeout", 32'(timeout), 0);
      check_eq("const_steps", 32'(nstep - n0), 1);

      // never recurs: times out at MAX_STEPS
      mode = 2;
      n0 = nstep;
      l0 = nload;
      run_meas(1'b0, b);
      check_eq("to_busy", 32'(b), 42);
      check_eq("to_period", 32'(period), 0);
      check_eq("to_valid", 32'(period_valid), 0);
      check_eq("to_timeout", 32'(timeout), 1);
      check_eq("to_steps", 32'(nstep - n0), 20);
      check_eq("to_loads", 32'(nload - l0), 1);

      // 4-bit LFSR, seed 5, with a manual request dropped while busy
      mode = 0;
      cyc();
      n0 = nstep;
      l0 = nload;
      run_meas(1'b1, b);
      check_eq("lfsr4_busy", 32'(b), 32);
      check_eq("lfsr4_period", 32'(period), 15);
      check_eq("lfsr4_valid", 32'(period_valid), 1);
      check_eq("lfsr4_timeout", 32'(timeout), 0);
      check_eq("lfsr4_steps", 32'(nstep - n0), 15);
      check_eq("lfsr4_loads", 32'(nload - l0), 1);
      cyc();
      check_eq("busy_nxt_dropped", 32'(nstep - n0), 15);

      // poly change during STEP aborts
      l0 = nload;
      meas_req = 1'b1;
      cyc();
      meas_req = 1'b0;
      wait_step("abort_reach_step");
      n0 = nstep;
      poly = 4'h2;
      cyc();
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_step", 32'(step), 0);
      repeat (3) cyc();
      check_eq("abort_steps", 32'(nstep - n0), 1);
      check_eq("abort_loads", 32'(nload - l0), 1);
      check_eq("abort_valid", 32'(period_valid), 0);
      check_eq("abort_period", 32'(period), 15);
      check_eq("abort_timeout", 32'(timeout), 0);
      run_meas(1'b0, b);
      check_eq("lfsr3_busy", 32'(b), 16);
      check_eq("lfsr3_period", 32'(period), 7);
      check_eq("lfsr3_valid", 32'(period_valid), 1);

      // async reset in CHK
      meas_req = 1'b1;
      cyc();
      meas_req = 1'b0;
      wait_step("rst_reach_step");
      cyc();
      check_eq("midrst_in_chk", 32'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_busy", 32'(busy), 0);
      check_eq("midrst_step", 32'(step), 0);
      check_eq("midrst_load", 32'(load), 0);
      check_eq("midrst_valid", 32'(period_valid), 0);
      check_eq("midrst_timeout", 32'(timeout), 0);
      check_eq("midrst_period", 32'(period), 0);
      repeat (2) cyc();
      rst = 1'b0;
      n0 = nstep;
      l0 = nload;
      repeat (4) cyc();
      check_eq("post_rst_steps", 32'(nstep - n0), 0);
      check_eq("post_rst_loads", 32'(nload - l0), 0);
      check_eq("post_rst_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
